// File: rtl/cpu_datapath_gen.sv
// cpu_datapath_gen: parametrised CPU datapath with AR, PC, DR, TR, IR, an
// NREG-entry register file, AC, ALU and flags on one muxed internal bus.
// Memory is reached through a req/ack port with stall and timeout.
//
// Optional feature: define FLAGS_EXT_EN to add the cout and nout flag outputs.
// AW must equal 2*DW so that {DR,TR} fills the bus.
//
// Memory handshake: the control unit raises mem_rd or mem_wr while the FSM is
// IDLE. The request is accepted on that edge, and address/data/we are latched.
// mem_req then stays high until the edge on which mem_ack=1 is seen, or until
// TMO_CYC BUSY cycles pass without an ack. stall tells the control unit to
// hold. It is high in the request cycle and in every BUSY cycle that has
// neither ack nor timeout. While stall is high, all ld[] strobes are masked.
module cpu_datapath_gen #(
    parameter int DW      = 8,
    parameter int AW      = 16,
    parameter int NREG    = 4,
    parameter int TMO_CYC = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic [9:0]              ld,
    input  logic [2:0]              bus_sel,
    input  logic [$clog2(NREG)-1:0] rsel,
    input  logic [3:0]              alus,
    input  logic                    mem_rd,
    input  logic                    mem_wr,
    input  logic                    mem_ack,
    input  logic [DW-1:0]           data_in,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [AW-1:0]           addr,
    output logic [DW-1:0]           data_out,
    output logic                    stall,
    output logic                    bus_err,
    output logic [DW-1:0]           irout,
    output logic [DW-1:0]           acdbus,
    output logic                    zout,
`ifdef FLAGS_EXT_EN
    output logic                    cout,
    output logic                    nout,
`endif
    output logic                    mem_state_dbg
);

    localparam int TCW = $clog2(TMO_CYC + 1);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} mem_state_t;

    mem_state_t         state_q;
    logic [TCW-1:0]     tmo_q;
    logic [AW-1:0]      ar_q, pc_q;
    logic [DW-1:0]      dr_q, tr_q, ir_q, ac_q;
    logic [DW-1:0]      rf_q [NREG];
    logic               z_q;
    logic [AW-1:0]      bus;
    logic [DW-1:0]      bus_lo;
    logic [DW-1:0]      alu_res;
    logic [9:0]         ld_ok;
    logic               rsel_ok;
    logic               busy;
    logic               timeout;
    logic               rd_done;

    assign busy    = (state_q == BUSY);
    assign timeout = busy && !mem_ack && (tmo_q == TCW'(TMO_CYC - 1));
    assign stall   = (!busy && (mem_rd || mem_wr)) || (busy && !mem_ack && !timeout);
    assign ld_ok   = stall ? 10'd0 : ld;
    assign rd_done = busy && mem_ack && !mem_we;
    assign rsel_ok = (int'(rsel) < NREG);
    assign bus_lo  = bus[DW-1:0];

    assign addr          = ar_q;
    assign irout         = ir_q;
    assign acdbus        = ac_q;
    assign zout          = z_q;
    assign mem_state_dbg = state_q;

    // Internal bus source mux; sel 3 concatenates DR:TR for address formation.
    always_comb begin
        bus = '0;
        case (bus_sel)
            3'd1: bus = pc_q;
            3'd2: bus = {{(AW-DW){1'b0}}, dr_q};
            3'd3: bus = {dr_q, tr_q};
            3'd4: bus = {{(AW-DW){1'b0}}, tr_q};
            3'd5: bus = rsel_ok ? {{(AW-DW){1'b0}}, rf_q[rsel]} : '0;
            3'd6: bus = {{(AW-DW){1'b0}}, ac_q};
            default: bus = '0;
        endcase
    end

    // ALU result, DW bits wide, wrapping modulo 2^DW.
    always_comb begin
        alu_res = ac_q;
        case (alus)
            4'd0:  alu_res = bus_lo;
            4'd1:  alu_res = ac_q + bus_lo;
            4'd2:  alu_res = ac_q - bus_lo;
            4'd3:  alu_res = ac_q & bus_lo;
            4'd4:  alu_res = ac_q | bus_lo;
            4'd5:  alu_res = ac_q ^ bus_lo;
            4'd6:  alu_res = ~ac_q;
            4'd7:  alu_res = ac_q + DW'(1);
            4'd8:  alu_res = ac_q - DW'(1);
            4'd9:  alu_res = '0;
            4'd10: alu_res = ac_q << 1;
            4'd11: alu_res = ac_q >> 1;
            default: alu_res = ac_q;
        endcase
    end

`ifdef FLAGS_EXT_EN
    logic alu_c;
    logic c_q, n_q;

    assign cout = c_q;
    assign nout = n_q;

    // Carry / no-borrow / shifted-out bit for the extended flags.
    always_comb begin
        alu_c = 1'b0;
        case (alus)
            4'd1:  alu_c = 1'((({1'b0, ac_q} + {1'b0, bus_lo}) >> DW));
            4'd2:  alu_c = 1'((({1'b0, ac_q} + {1'b0, ~bus_lo} + (DW+1)'(1)) >> DW));
            4'd7:  alu_c = &ac_q;
            4'd8:  alu_c = |ac_q;
            4'd10: alu_c = ac_q[DW-1];
            4'd11: alu_c = ac_q[0];
            default: alu_c = 1'b0;
        endcase
    end

    // Extended flag registers, loaded together with Z.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c_q <= 1'b0;
            n_q <= 1'b0;
        end else if (clr) begin
            c_q <= 1'b0;
            n_q <= 1'b0;
        end else if (ld_ok[9]) begin
            c_q <= alu_c;
            n_q <= alu_res[DW-1];
        end
    end
`endif

    // Memory FSM: accepts a request in IDLE and waits for ack or timeout in BUSY.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            tmo_q    <= '0;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            data_out <= '0;
            bus_err  <= 1'b0;
        end else if (clr) begin
            state_q  <= IDLE;
            tmo_q    <= '0;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            data_out <= '0;
            bus_err  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mem_rd || mem_wr) begin
                        state_q  <= BUSY;
                        tmo_q    <= '0;
                        mem_req  <= 1'b1;
                        mem_we   <= !mem_rd;
                        data_out <= bus_lo;
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        state_q <= IDLE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                    end else if (timeout) begin
                        state_q <= IDLE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        bus_err <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + TCW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Datapath registers; a read ack takes priority over a bus load of DR.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ar_q <= '0;
            pc_q <= '0;
            dr_q <= '0;
            tr_q <= '0;
            ir_q <= '0;
            ac_q <= '0;
            z_q  <= 1'b0;
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else if (clr) begin
            ar_q <= '0;
            pc_q <= '0;
            dr_q <= '0;
            tr_q <= '0;
            ir_q <= '0;
            ac_q <= '0;
            z_q  <= 1'b0;
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else begin
            if (ld_ok[0])      ar_q <= bus;
            else if (ld_ok[1]) ar_q <= ar_q + AW'(1);
            if (ld_ok[2])      pc_q <= bus;
            else if (ld_ok[3]) pc_q <= pc_q + AW'(1);
            if (rd_done)       dr_q <= data_in;
            else if (ld_ok[4]) dr_q <= bus_lo;
            if (ld_ok[5])      tr_q <= dr_q;
            if (ld_ok[6])      ir_q <= dr_q;
            if (ld_ok[7] && rsel_ok) rf_q[rsel] <= bus_lo;
            if (ld_ok[8])      ac_q <= alu_res;
            if (ld_ok[9])      z_q  <= (alu_res == '0);
        end
    end

endmodule

// File: tb/tb_cpu_datapath_gen.sv
// Directed bench for cpu_datapath_gen: reset, memory read/write/timeout,
// PC/AR arithmetic and an ALU sequence with hand-computed results.
module tb_cpu_datapath_gen;

    localparam int DW = 8;
    localparam int AW = 16;
    localparam int NREG = 4;
    localparam int TMO = 15;

    logic          clk = 1'b0;
    logic          rst, clr;
    logic [9:0]    ld;
    logic [2:0]    bus_sel;
    logic [1:0]    rsel;
    logic [3:0]    alus;
    logic          mem_rd, mem_wr, mem_ack;
    logic [DW-1:0] data_in;
    logic          mem_req, mem_we, stall, bus_err, zout, mem_state_dbg;
    logic [AW-1:0] addr;
    logic [DW-1:0] data_out, irout, acdbus;
`ifdef FLAGS_EXT_EN
    logic          cout, nout;
`endif

    int n_checks = 0;
    int n_errs = 0;
    logic [DW-1:0] exp_q[$];

    // Clock generation.
    always #5 clk = ~clk;

    cpu_datapath_gen #(.DW(DW), .AW(AW), .NREG(NREG), .TMO_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .clr(clr), .ld(ld), .bus_sel(bus_sel), .rsel(rsel),
        .alus(alus), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_ack(mem_ack),
        .data_in(data_in), .mem_req(mem_req), .mem_we(mem_we), .addr(addr),
        .data_out(data_out), .stall(stall), .bus_err(bus_err), .irout(irout),
        .acdbus(acdbus), .zout(zout),
`ifdef FLAGS_EXT_EN
        .cout(cout), .nout(nout),
`endif
        .mem_state_dbg(mem_state_dbg)
    );

    function automatic logic [9:0] lb(input int n);
        return 10'(1) << n;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Read one byte into DR, acked in the first BUSY cycle.
    task automatic mem_read(input logic [DW-1:0] d);
        ld = '0;
        mem_rd = 1'b1;
        tick();
        mem_rd = 1'b0;
        mem_ack = 1'b1;
        data_in = d;
        tick();
        mem_ack = 1'b0;
    endtask

    // Copy DR into AC so it becomes observable on acdbus.
    task automatic show_dr();
        bus_sel = 3'd2;
        alus = 4'd0;
        ld = lb(8);
        tick();
        ld = '0;
    endtask

    int n;
    logic [3:0] t_op [13] = '{4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd10, 4'd11, 4'd7, 4'd8, 4'd4, 4'd9, 4'd13, 4'd0};
    logic       t_lz [13] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [7:0] t_ac [13] = '{8'h00, 8'hFF, 8'h01, 8'h00, 8'hFF, 8'hFE, 8'h7F, 8'h80, 8'h7F, 8'h7F, 8'h00, 8'h00, 8'h01};
    logic       t_z  [13] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Main directed sequence.
    initial begin
        rst = 1'b0; clr = 1'b0; ld = '0; bus_sel = '0; rsel = '0; alus = '0;
        mem_rd = 1'b0; mem_wr = 1'b0; mem_ack = 1'b0; data_in = '0;
        repeat (2) tick();
        check_eq("rst_addr", addr, 0);
        check_eq("rst_ac", acdbus, 0);
        check_eq("rst_ir", irout, 0);
        check_eq("rst_z", zout, 0);
        check_eq("rst_req", mem_req, 0);
        check_eq("rst_we", mem_we, 0);
        check_eq("rst_dout", data_out, 0);
        check_eq("rst_stall", stall, 0);
        check_eq("rst_err", bus_err, 0);
        rst = 1'b1;
        tick();

        // Reset in the middle of a read access.
        mem_rd = 1'b1;
        #1 check_eq("req_cycle_stall", stall, 1);
        tick();
        mem_rd = 1'b0;
        check_eq("busy_req", mem_req, 1);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check_eq("midrst_req", mem_req, 0);
        check_eq("midrst_stall", stall, 0);
        check_eq("midrst_err", bus_err, 0);
        check_eq("midrst_state", mem_state_dbg, 0);
        tick();
        rst = 1'b1;
        mem_ack = 1'b1;
        data_in = 8'h77;
        tick();
        mem_ack = 1'b0;
        check_eq("idle_ack_req", mem_req, 0);
        show_dr();
        check_eq("midrst_dr", acdbus, 8'h00);

        // AR = 0x1234, then a read acked in the third BUSY cycle.
        mem_read(8'h34);
        ld = lb(5); tick(); ld = '0;
        mem_read(8'h12);
        bus_sel = 3'd3; ld = lb(0); tick(); ld = '0;
        check_eq("ar_1234", addr, 16'h1234);
        mem_rd = 1'b1;
        tick();
        mem_rd = 1'b0;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            if (mem_req) n++;
            if (i == 2) begin
                mem_ack = 1'b1; data_in = 8'hA5; bus_sel = 3'd0; ld = lb(4);
                #1 check_eq("ack_stall", stall, 0);
            end else begin
                check_eq("busy_stall", stall, 1);
            end
            tick();
        end
        mem_ack = 1'b0; ld = '0;
        check_eq("rd_req_cycles", n, 3);
        check_eq("rd_req_drop", mem_req, 0);
        check_eq("rd_addr", addr, 16'h1234);
        ld = lb(6); tick(); ld = '0;
        check_eq("ir_a5", irout, 8'hA5);
        show_dr();
        check_eq("dr_ack_wins", acdbus, 8'hA5);

        // Read that never gets an ack.
        mem_read(8'h5A);
        mem_rd = 1'b1;
        tick();
        mem_rd = 1'b0;
        n = 0;
        while (mem_req && n < 40) begin
            n++;
            if (n == 14) check_eq("tmo_stall14", stall, 1);
            if (n == 15) check_eq("tmo_stall15", stall, 0);
            tick();
        end
        check_eq("tmo_cycles", n, TMO);
        check_eq("tmo_err", bus_err, 1);
        check_eq("tmo_req", mem_req, 0);
        check_eq("tmo_stall", stall, 0);
        show_dr();
        check_eq("tmo_dr", acdbus, 8'h5A);
        mem_read(8'h11);
        check_eq("err_sticky", bus_err, 1);
        clr = 1'b1; tick(); clr = 1'b0;
        check_eq("clr_err", bus_err, 0);
        check_eq("clr_ac", acdbus, 0);
        check_eq("clr_addr", addr, 0);

        // ALU sequence: AC=0xFF, R[1]=0x01, then ops on bus = R[1].
        mem_read(8'hFF);
        show_dr();
        mem_read(8'h01);
        bus_sel = 3'd2; rsel = 2'd1; ld = lb(7); tick(); ld = '0;
        for (int i = 0; i < 13; i++) exp_q.push_back(t_ac[i]);
        for (int i = 0; i < 13; i++) begin
            bus_sel = 3'd5; rsel = 2'd1; alus = t_op[i];
            ld = t_lz[i] ? (lb(8) | lb(9)) : lb(8);
            tick();
            ld = '0;
            check_eq($sformatf("alu%0d_ac", i), acdbus, exp_q.pop_front());
            check_eq($sformatf("alu%0d_z", i), zout, t_z[i]);
`ifdef FLAGS_EXT_EN
            if (i == 0) begin
                check_eq("add_cout", cout, 1);
                check_eq("add_nout", nout, 0);
            end
`endif
        end

        // PC wrap, load-over-increment, AR increment.
        mem_read(8'hFF);
        ld = lb(5); tick();
        bus_sel = 3'd3; ld = lb(2); tick();
        bus_sel = 3'd1; ld = lb(0); tick(); ld = '0;
        check_eq("pc_ffff", addr, 16'hFFFF);
        ld = lb(3); tick();
        bus_sel = 3'd1; ld = lb(0); tick(); ld = '0;
        check_eq("pc_wrap", addr, 16'h0000);
        mem_read(8'h00);
        ld = lb(5); tick(); ld = '0;
        mem_read(8'h01);
        bus_sel = 3'd3; ld = lb(2) | lb(3); tick();
        bus_sel = 3'd1; ld = lb(0); tick(); ld = '0;
        check_eq("pc_load_wins", addr, 16'h0100);
        ld = lb(1); tick(); ld = '0;
        check_eq("ar_inc", addr, 16'h0101);
        bus_sel = 3'd1; ld = lb(0) | lb(1); tick(); ld = '0;
        check_eq("ar_load_wins", addr, 16'h0100);

        // Write of AC with ld[8] held through the stall.
        mem_read(8'h3C);
        show_dr();
        bus_sel = 3'd6; alus = 4'd7; ld = lb(8); mem_wr = 1'b1;
        #1 check_eq("wr_req_stall", stall, 1);
        tick();
        mem_wr = 1'b0;
        check_eq("wr_req", mem_req, 1);
        check_eq("wr_we", mem_we, 1);
        check_eq("wr_dout", data_out, 8'h3C);
        check_eq("wr_ac_hold0", acdbus, 8'h3C);
        tick();
        tick();
        check_eq("wr_ac_hold2", acdbus, 8'h3C);
        check_eq("wr_we_held", mem_we, 1);
        mem_ack = 1'b1;
        #1 check_eq("wr_ack_stall", stall, 0);
        tick();
        mem_ack = 1'b0; ld = '0;
        check_eq("wr_ac_adv", acdbus, 8'h3D);
        check_eq("wr_req_drop", mem_req, 0);
        check_eq("wr_dout_kept", data_out, 8'h3C);
        show_dr();
        check_eq("wr_dr_kept", acdbus, 8'h3C);

        // Read has priority when both strobes are set.
        mem_rd = 1'b1; mem_wr = 1'b1;
        tick();
        mem_rd = 1'b0; mem_wr = 1'b0;
        check_eq("rdwr_we", mem_we, 0);
        mem_ack = 1'b1; data_in = 8'h42;
        tick();
        mem_ack = 1'b0;
        show_dr();
        check_eq("rdwr_dr", acdbus, 8'h42);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
